// File: rtl/alu_seq_core.sv
// Sequential ALU core: accumulator, register file, {Z,C,N,V} flags, start/busy/done handshake.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (MUL) and the HI register.
module alu_seq_core #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [3:0]               op,
  input  logic [$clog2(NREGS)-1:0] reg_sel,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic [3:0]               flags
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;
  localparam logic [3:0] OP_MFH = 4'hB;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] rf_d [NREGS];
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] operand;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             wr_acc;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] prod_step;
`endif

  assign operand  = rf_q[reg_sel];
  assign sum_ext  = {1'b0, acc_q} + {1'b0, operand};
  assign diff_ext = {1'b0, acc_q} - {1'b0, operand};

`ifdef ALU_MUL_EN
  // Low half of prod holds the remaining multiplier bits; each step adds and shifts right.
  assign step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step = {step_sum, prod_q[WIDTH-1:1]};
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rf_d    = rf_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    wr_acc  = 1'b0;
`ifdef ALU_MUL_EN
    hi_d    = hi_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d = 1'b1;
          case (op)
            OP_LDA: begin
              acc_d  = data_in;
              wr_acc = 1'b1;
            end
            OP_STA: rf_d[reg_sel] = acc_q;
            OP_ADD: begin
              acc_d      = sum_ext[WIDTH-1:0];
              flags_d[2] = sum_ext[WIDTH];
              flags_d[0] = (acc_q[WIDTH-1] == operand[WIDTH-1]) &&
                           (sum_ext[WIDTH-1] != acc_q[WIDTH-1]);
              wr_acc     = 1'b1;
            end
            OP_SUB: begin
              acc_d      = diff_ext[WIDTH-1:0];
              flags_d[2] = diff_ext[WIDTH];
              flags_d[0] = (acc_q[WIDTH-1] != operand[WIDTH-1]) &&
                           (diff_ext[WIDTH-1] != acc_q[WIDTH-1]);
              wr_acc     = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
              if (op == OP_AND)     acc_d = acc_q & operand;
              else if (op == OP_OR) acc_d = acc_q | operand;
              else                  acc_d = acc_q ^ operand;
              flags_d[2] = 1'b0;
              flags_d[0] = 1'b0;
              wr_acc     = 1'b1;
            end
            OP_SHL: begin
              acc_d      = {acc_q[WIDTH-2:0], 1'b0};
              flags_d[2] = acc_q[WIDTH-1];
              flags_d[0] = 1'b0;
              wr_acc     = 1'b1;
            end
            OP_SHR: begin
              acc_d      = {1'b0, acc_q[WIDTH-1:1]};
              flags_d[2] = acc_q[0];
              flags_d[0] = 1'b0;
              wr_acc     = 1'b1;
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
              done_d  = 1'b0;
              mcand_d = acc_q;
              prod_d  = {{WIDTH{1'b0}}, operand};
              cnt_d   = '0;
              state_d = ST_MUL;
            end
            OP_MFH: begin
              acc_d  = hi_q;
              wr_acc = 1'b1;
            end
`else
            OP_MFH: begin
              acc_d  = '0;
              wr_acc = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_MUL: begin
`ifdef ALU_MUL_EN
        prod_d = prod_step;
        if (cnt_q == CW'(WIDTH - 1)) begin
          acc_d      = prod_step[WIDTH-1:0];
          hi_d       = prod_step[2*WIDTH-1:WIDTH];
          flags_d[2] = |prod_step[2*WIDTH-1:WIDTH];
          flags_d[0] = |prod_step[2*WIDTH-1:WIDTH];
          wr_acc     = 1'b1;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_acc) begin
      flags_d[3] = (acc_d == '0);
      flags_d[1] = acc_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
`ifdef ALU_MUL_EN
      hi_q    <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
`ifdef ALU_MUL_EN
      hi_q    <= hi_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign busy   = (state_q == ST_MUL);
  assign done   = done_q;
  assign result = acc_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core: an operation-level reference model checked every cycle, plus pinned
// literal expectations; covers both the ALU_MUL_EN and the default build.
module tb_alu_seq_core;

  localparam int W  = 8;
  localparam int NR = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic [3:0]   op;
  logic [1:0]   reg_sel;
  logic         start;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [3:0]   flags;

  alu_seq_core #(.WIDTH(W), .NREGS(NR)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .op      (op),
    .reg_sel (reg_sel),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .flags   (flags)
  );

  always #5 clk = ~clk;

  int cyc_checks = 0;
  int cyc_errors = 0;
  int lit_checks = 0;
  int lit_errors = 0;
  bit check_en   = 1'b0;
  int busy_total = 0;
  int done_total = 0;

  // Reference model: state updated once per rising edge from the opcode rules.
  logic [W-1:0]   m_acc, m_hi;
  logic [W-1:0]   m_rf [NR];
  logic           mz, mc, mn, mv, m_busy, m_done;
  int             m_cnt;
  logic [2*W-1:0] m_prod;

  always @(posedge clk) begin
    int ua, ur, sa, sr, res, sres;
    bit wr;
    if (!rst_n) begin
      m_acc = '0; m_hi = '0;
      for (int i = 0; i < NR; i++) m_rf[i] = '0;
      mz = 0; mc = 0; mn = 0; mv = 0;
      m_busy = 0; m_done = 0; m_cnt = 0; m_prod = '0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_acc  = m_prod[W-1:0];
          m_hi   = m_prod[2*W-1:W];
          mc     = (m_hi != 0);
          mv     = mc;
          mz     = (m_acc == 0);
          mn     = m_acc[W-1];
          m_busy = 0;
          m_done = 1;
        end
      end else if (start) begin
        ua = int'(m_acc);
        ur = int'(m_rf[reg_sel]);
        sa = int'($signed(m_acc));
        sr = int'($signed(m_rf[reg_sel]));
        res = 0;
        wr = 1;
        m_done = 1;
        case (op)
          4'h1: res = int'(data_in);
          4'h2: begin m_rf[reg_sel] = m_acc; wr = 0; end
          4'h3: begin
            res = ua + ur; sres = sa + sr;
            mc = (res >= (1 << W));
            mv = (sres > (1 << (W-1)) - 1) || (sres < -(1 << (W-1)));
          end
          4'h4: begin
            res = ua - ur; sres = sa - sr;
            mc = (ur > ua);
            mv = (sres > (1 << (W-1)) - 1) || (sres < -(1 << (W-1)));
          end
          4'h5: begin res = ua & ur; mc = 0; mv = 0; end
          4'h6: begin res = ua | ur; mc = 0; mv = 0; end
          4'h7: begin res = ua ^ ur; mc = 0; mv = 0; end
          4'h8: begin res = ua * 2; mc = (ua >= (1 << (W-1))); mv = 0; end
          4'h9: begin res = ua / 2; mc = (ua % 2) == 1; mv = 0; end
          4'hA: begin
            wr = 0;
`ifdef ALU_MUL_EN
            m_prod = (2*W)'(ua * ur);
            m_busy = 1;
            m_cnt  = W;
            m_done = 0;
`endif
          end
          4'hB: res = int'(m_hi);
          default: wr = 0;
        endcase
        if (wr) begin
          m_acc = W'(res);
          mz = (m_acc == 0);
          mn = m_acc[W-1];
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      cyc_checks++;
      if (result !== m_acc || flags !== {mz, mc, mn, mv} || busy !== m_busy || done !== m_done) begin
        cyc_errors++;
        $display("[TB] FAIL cycle t=%0t: got result=%h flags=%b busy=%b done=%b, expected result=%h flags=%b busy=%b done=%b",
                 $time, result, flags, busy, done, m_acc, {mz, mc, mn, mv}, m_busy, m_done);
      end
    end
  end

  always @(negedge clk) begin
    if (busy === 1'b1) busy_total++;
    if (done === 1'b1) done_total++;
  end

  task automatic apply_stimulus(input logic [3:0] o, input logic [1:0] sel, input logic [W-1:0] d);
    start   = 1'b1;
    op      = o;
    reg_sel = sel;
    data_in = d;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
    lit_checks++;
    if (actual !== expected) begin
      lit_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  int d0, b0;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 4'h0; reg_sel = '0; data_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;
    check_output("reset_result", 16'(result), 16'h00);
    check_output("reset_flags", 16'(flags), 16'h0);
    check_output("reset_busy_done", 16'({busy, done}), 16'h0);

    // ADD overflow
    d0 = done_total;
    apply_stimulus(4'h1, 2'd0, 8'h7F);
    apply_stimulus(4'h2, 2'd1, 8'h00);
    apply_stimulus(4'h3, 2'd1, 8'h00);
    check_output("add_result", 16'(result), 16'h00FE);
    check_output("add_flags", 16'(flags), 16'b0011);
    @(negedge clk);
    check_output("add_done_count", 16'(done_total - d0), 16'd3);

    // SUB borrow, then AND
    apply_stimulus(4'h1, 2'd0, 8'h05);
    apply_stimulus(4'h2, 2'd2, 8'h00);
    apply_stimulus(4'h1, 2'd0, 8'h03);
    apply_stimulus(4'h4, 2'd2, 8'h00);
    check_output("sub_result", 16'(result), 16'h00FE);
    check_output("sub_flags", 16'(flags), 16'b0110);
    apply_stimulus(4'h5, 2'd2, 8'h00);
    check_output("and_result", 16'(result), 16'h0004);
    check_output("and_flags", 16'(flags), 16'b0000);
    apply_stimulus(4'h6, 2'd1, 8'h00);
    apply_stimulus(4'h7, 2'd2, 8'h00);
    apply_stimulus(4'hF, 2'd0, 8'h00);

    // MUL with an ignored start mid-operation and a start during the done cycle
    apply_stimulus(4'h1, 2'd0, 8'h0D);
    apply_stimulus(4'h2, 2'd0, 8'h00);
    apply_stimulus(4'h1, 2'd0, 8'h14);
    b0 = busy_total;
    apply_stimulus(4'hA, 2'd0, 8'h00);
`ifdef ALU_MUL_EN
    repeat (2) @(negedge clk);
    apply_stimulus(4'h3, 2'd1, 8'h00);
    for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
    check_output("mul_done_seen", 16'(done), 16'h1);
    check_output("mul_result", 16'(result), 16'h0004);
    check_output("mul_flags", 16'(flags), 16'b0101);
    check_output("mul_busy_cycles", 16'(busy_total - b0), 16'd8);
    apply_stimulus(4'hB, 2'd0, 8'h00);
    check_output("mfh_result", 16'(result), 16'h0001);
    check_output("mfh_flags", 16'(flags), 16'b0101);
`else
    check_output("mul_nop_done", 16'(done), 16'h1);
    check_output("mul_nop_result", 16'(result), 16'h0014);
    @(negedge clk);
    check_output("mul_nop_busy_cycles", 16'(busy_total - b0), 16'd0);
    apply_stimulus(4'hB, 2'd0, 8'h00);
    check_output("mfh_nop_result", 16'(result), 16'h0000);
    check_output("mfh_nop_z", 16'(flags[3]), 16'h1);
    check_output("mfh_nop_n", 16'(flags[1]), 16'h0);
`endif

    // Reset during a MUL
    apply_stimulus(4'h1, 2'd0, 8'h33);
    apply_stimulus(4'hA, 2'd0, 8'h00);
    @(negedge clk);
    d0 = done_total;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_output("rst_mid_result", 16'(result), 16'h00);
    check_output("rst_mid_flags", 16'(flags), 16'h0);
    check_output("rst_mid_busy", 16'(busy), 16'h0);
    repeat (12) @(negedge clk);
    check_output("rst_mid_no_done", 16'(done_total - d0), 16'd0);
    apply_stimulus(4'h1, 2'd0, 8'h11);
    apply_stimulus(4'h3, 2'd1, 8'h00);
    check_output("rst_regfile_cleared", 16'(result), 16'h0011);

    // Shifts
    apply_stimulus(4'h1, 2'd0, 8'h81);
    apply_stimulus(4'h9, 2'd0, 8'h00);
    check_output("shr_result", 16'(result), 16'h0040);
    check_output("shr_flags", 16'(flags), 16'b0100);
    apply_stimulus(4'h1, 2'd0, 8'h81);
    apply_stimulus(4'h8, 2'd0, 8'h00);
    check_output("shl_result", 16'(result), 16'h0002);
    check_output("shl_flags", 16'(flags), 16'b0100);

`ifdef ALU_MUL_EN
    // MUL with zero HI, then back-to-back single-cycle issue
    apply_stimulus(4'h1, 2'd0, 8'h03);
    apply_stimulus(4'h2, 2'd3, 8'h00);
    apply_stimulus(4'hA, 2'd3, 8'h00);
    for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
    check_output("mul_small_result", 16'(result), 16'h0009);
    check_output("mul_small_flags", 16'(flags), 16'b0000);
`endif
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", cyc_checks + lit_checks, cyc_errors + lit_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised sequential ALU core with an accumulator, a small register file, status flags and an optional iterative shift-add multiplier. Each operation is issued with a start/busy/done handshake. It is the next-generation ALU/control datapath instantiated under the TinyTapeout top level: dedicated inputs feed `data_in`, bidirectional inputs feed the control fields, and `result` drives the dedicated outputs.

## Interface
Parameters:
- `WIDTH`, 8: datapath width of ACC, HI, register file, `data_in` and `result`; minimum 4.
- `NREGS`, 4: register file depth; power of two, minimum 2.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `data_in`  in  WIDTH  immediate operand for LDA.
- `op`  in  4  opcode, sampled on the accepting edge.
- `reg_sel`  in  $clog2(NREGS)  register index, sampled on the accepting edge.
- `start`  in  1  issue request.
- `busy`  out  1  multi-cycle op in progress.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  WIDTH  current ACC value.
- `flags`  out  4  {Z,C,N,V}, registered.

## Operation
- Acceptance: a start is accepted on a rising edge where `start`=1 and `busy`=0. A start while `busy`=1 is ignored; it is not queued.
- Opcodes; R = R[reg_sel]:
  - 0x0 NOP.
  - 0x1 LDA: ACC<=data_in.
  - 0x2 STA: R<=ACC.
  - 0x3 ADD: ACC<=ACC+R.
  - 0x4 SUB: ACC<=ACC−R.
  - 0x5 AND, 0x6 OR, 0x7 XOR: ACC<=ACC op R.
  - 0x8 SHL: ACC<<1, zero fill.
  - 0x9 SHR: ACC>>1, logical.
  - 0xA MUL: {HI,ACC}<=ACC×R, unsigned, 2·WIDTH-bit product.
  - 0xB MFH: ACC<=HI.
  - 0xC–0xF: NOP.
- Flag updates:
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = borrow (1 when R>ACC unsigned); V = signed overflow.
  - AND/OR/XOR: C=0, V=0.
  - SHL/SHR: C = bit shifted out; V=0.
  - MUL: C=V=(HI≠0).
  - LDA/MFH: update Z and N only.
  - STA/NOP: all flags unchanged.
  - Z = (new ACC==0) and N = new ACC MSB, for every op that writes ACC.
- MUL runs on internal multiplicand, multiplier and partial-product registers. ACC, HI and flags stay unchanged until the final writeback.
- Register file contents are written only by STA.
- Reset clears ACC, HI, all R[i], flags, `busy` and `done` to 0.

## Timing
- Single-cycle ops accepted at edge N: ACC/R/flags update at edge N; `done`=1 during cycle N→N+1; `busy` stays 0.
- MUL accepted at edge N:
  - `busy`=1 during exactly WIDTH cycles, from N through edge N+WIDTH.
  - At edge N+WIDTH, ACC/HI/flags are written, `busy` falls and `done`=1 for one cycle.
- A start presented while `done`=1 is accepted; back-to-back issue is legal.
- `result` always equals ACC, with zero combinational path from inputs.
- Reset asserted mid-MUL aborts the op: no writeback and no `done` pulse. State reads zero on the edge after reset sampling.
- Reset takes priority over `start` on the same edge.

## Configuration
- `ALU_MUL_EN` defined: the multiplier is built, and MUL behaves as specified above.
- `ALU_MUL_EN` undefined: the multiplier logic and HI register are removed.
  - MUL (0xA) behaves as NOP: `done` pulses one cycle after acceptance, `busy` never asserts, flags are unchanged.
  - MFH loads 0 into ACC and sets Z=1, N=0.

## Test plan
All scenarios use WIDTH=8, NREGS=4, `ALU_MUL_EN` defined unless stated.
- ADD overflow: reset, LDA 0x7F, STA r1, ADD r1 -> `result`=0xFE, flags Z0 C0 N1 V1, `done` pulses once per op.
- SUB borrow: LDA 0x05, STA r2, LDA 0x03, SUB r2 -> 0xFE, C=1, N=1, V=0; then AND r2 -> 0x04, C=0.
- MUL: LDA 0x0D, STA r0, LDA 0x14, MUL r0 -> `busy` high 8 cycles, then `done`, ACC=0x04, C=V=1; MFH -> ACC=0x01.
- Handshake: assert `start` with ADD during MUL cycle 3 -> ignored, ACC still 0x04 after MUL; start asserted during the `done` cycle -> accepted.
- Reset mid-MUL: assert `rst_n`=0 at MUL cycle 4 -> ACC, HI, flags, `busy` all 0, no `done` pulse.
- Shift and macro: LDA 0x81, SHR -> 0x40, C=1. Rebuilt without `ALU_MUL_EN`: MUL -> `done` after 1 cycle, ACC unchanged, `busy` never high; MFH -> 0x00, Z=1.
